bit_word_pacer: RTL and testbench

- Parametrised successor to the fixed divide-by-8 read-clock generator.
- Counts serial bit ticks in the system clock domain and issues one registered FIFO read strobe per WORD_BITS bits.
- Adds frame length control, start/abort, a prefetch mode and underrun detection.
- Sits between the SPI/serial bit-tick generator and the transmit FIFO read port in the DAQ Wi-Fi path.

---
 rtl/bit_word_pacer_if.sv | 29 ++
 rtl/bit_word_pacer.sv | 133 +++++++++++++
 tb/tb_bit_word_pacer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_word_pacer_if.sv
// Signal bundle between the serial bit-tick source, the word pacer and the TX FIFO read port.
interface bit_word_pacer_if #(
  parameter int WORD_BITS = 8,
  parameter int FRAME_W   = 16
);
  localparam int CNT_W = $clog2(WORD_BITS);

  logic               start;
  logic               abort;
  logic               bit_tick;
  logic [FRAME_W-1:0] frame_words;
  logic               fifo_empty;
  logic               rd_en;
  logic [CNT_W-1:0]   bit_idx;
  logic [FRAME_W-1:0] word_cnt;
  logic               busy;
  logic               frame_done;
  logic               underrun;

  modport master (
    output start, abort, bit_tick, frame_words, fifo_empty,
    input  rd_en, bit_idx, word_cnt, busy, frame_done, underrun
  );

  modport slave (
    input  start, abort, bit_tick, frame_words, fifo_empty,
    output rd_en, bit_idx, word_cnt, busy, frame_done, underrun
  );
endinterface

// File: rtl/bit_word_pacer.sv
// Counts serial bit ticks and issues one registered FIFO read strobe per WORD_BITS bits,
// with frame length control, start/abort, optional one-word prefetch and sticky underrun.
module bit_word_pacer #(
  parameter int WORD_BITS = 8,
  parameter int FRAME_W   = 16,
  parameter int PREFETCH  = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  bit_word_pacer_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] word_cnt_q, word_cnt_d;
  logic [FRAME_W-1:0] len_q, len_d;
  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               underrun_q, underrun_d;
  logic               strobe_due_s;
  logic               last_word_s;
  logic [FRAME_W:0]   word_inc_s;

  // Next-state, counter and strobe decision logic.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    underrun_d   = underrun_q;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;
    strobe_due_s = 1'b0;
    // One extra bit keeps the last-word compare exact for a 2^FRAME_W-1 word frame.
    word_inc_s   = {1'b0, word_cnt_q} + {{FRAME_W{1'b0}}, 1'b1};
    last_word_s  = (word_inc_s == {1'b0, len_q});

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          underrun_d = 1'b0;
          word_cnt_d = {FRAME_W{1'b0}};
          bit_idx_d  = {CNT_W{1'b0}};
          if (bus.frame_words != {FRAME_W{1'b0}}) begin
            state_d      = S_RUN;
            len_d        = bus.frame_words;
            strobe_due_s = (PREFETCH != 0);
          end else begin
            frame_done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d    = S_IDLE;
          bit_idx_d  = {CNT_W{1'b0}};
          word_cnt_d = {FRAME_W{1'b0}};
        end else if (bus.bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d    = {CNT_W{1'b0}};
            word_cnt_d   = word_inc_s[FRAME_W-1:0];
            strobe_due_s = (PREFETCH == 0) || !last_word_s;
            if (last_word_s) begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            bit_idx_d = bit_idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (strobe_due_s) begin
      if (bus.fifo_empty) begin
        underrun_d = 1'b1;
      end else begin
        rd_en_d = 1'b1;
      end
    end else begin
      rd_en_d = 1'b0;
    end

    busy_d = (state_d == S_RUN);
  end

  // State and registered output flops with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      bit_idx_q    <= {CNT_W{1'b0}};
      word_cnt_q   <= {FRAME_W{1'b0}};
      len_q        <= {FRAME_W{1'b0}};
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.word_cnt   = word_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_bit_word_pacer.sv
// Scoreboard bench for bit_word_pacer: three instances cover default, prefetch and 12-bit/4-bit-frame configurations.
module tb_bit_word_pacer;
  logic sys_clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  bit_word_pacer_if #(.WORD_BITS(8),  .FRAME_W(16)) ia ();
  bit_word_pacer_if #(.WORD_BITS(8),  .FRAME_W(16)) ib ();
  bit_word_pacer_if #(.WORD_BITS(12), .FRAME_W(4))  ic ();

  bit_word_pacer #(.WORD_BITS(8),  .FRAME_W(16), .PREFETCH(0)) u_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ia.slave));
  bit_word_pacer #(.WORD_BITS(8),  .FRAME_W(16), .PREFETCH(1)) u_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ib.slave));
  bit_word_pacer #(.WORD_BITS(12), .FRAME_W(4),  .PREFETCH(0)) u_c (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ic.slave));

  typedef struct {
    int cyc;
    bit rd;
    bit fd;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int c, input bit rd, input bit fd);
    ev_t e;
    e.cyc = c;
    e.rd  = rd;
    e.fd  = fd;
    case (id)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int id, input bit rd, input bit fd);
    ev_t e;
    bit  have = 1'b0;
    case (id)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk($sformatf("unexpected_event_dut%0d_rd_fd", id), {rd, fd}, 0);
    end else begin
      chk($sformatf("event_cycle_dut%0d", id), cyc, e.cyc);
      chk($sformatf("event_rd_en_dut%0d", id), rd, e.rd);
      chk($sformatf("event_frame_done_dut%0d", id), fd, e.fd);
    end
  endtask

  // Monitor: every presented strobe or frame_done is matched against the scoreboard.
  always @(negedge sys_clk) begin
    if (ia.rd_en === 1'b1 || ia.frame_done === 1'b1) pop_cmp(0, ia.rd_en, ia.frame_done);
    if (ib.rd_en === 1'b1 || ib.frame_done === 1'b1) pop_cmp(1, ib.rd_en, ib.frame_done);
    if (ic.rd_en === 1'b1 || ic.frame_done === 1'b1) pop_cmp(2, ic.rd_en, ic.frame_done);
  end

  task automatic set_in(input int id, input bit st, input bit ab, input bit tk, input bit fe, input int fw);
    case (id)
      0: begin ia.start = st; ia.abort = ab; ia.bit_tick = tk; ia.fifo_empty = fe; ia.frame_words = fw[15:0]; end
      1: begin ib.start = st; ib.abort = ab; ib.bit_tick = tk; ib.fifo_empty = fe; ib.frame_words = fw[15:0]; end
      default: begin ic.start = st; ic.abort = ab; ic.bit_tick = tk; ic.fifo_empty = fe; ic.frame_words = fw[3:0]; end
    endcase
  endtask

  task automatic pulse_start(input int id, input int fw);
    set_in(id, 1'b1, 1'b0, 1'b0, 1'b0, fw);
    @(negedge sys_clk);
    set_in(id, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Ticks k_from..k_to; expected strobes at word boundaries (multiples of wb), fifo_empty at skip.
  task automatic run_ticks(input int id, input int k_from, input int k_to, input int gap,
                           input int wb, input int last, input int skip, input bit pf);
    bit rd;
    bit fd;
    for (int k = k_from; k <= k_to; k++) begin
      repeat (gap - 1) @(negedge sys_clk);
      set_in(id, 1'b0, 1'b0, 1'b1, (k == skip), 0);
      if (k % wb == 0) begin
        rd = (k != skip) && !(pf && k == last);
        fd = (k == last);
        if (rd || fd) push(id, cyc + 1, rd, fd);
      end
      @(negedge sys_clk);
      set_in(id, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", ia.busy, 0);
    chk("rst_rd_en", ia.rd_en, 0);
    chk("rst_frame_done", ia.frame_done, 0);
    chk("rst_underrun", ia.underrun, 0);
    chk("rst_bit_idx", ia.bit_idx, 0);
    chk("rst_word_cnt", ia.word_cnt, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Basic 3-word frame, ticks every 4 cycles.
    pulse_start(0, 3);
    chk("t1_busy_rise", ia.busy, 1);
    run_ticks(0, 1, 24, 4, 8, 24, 0, 1'b0);
    chk("t1_word_cnt", ia.word_cnt, 3);
    chk("t1_busy_low", ia.busy, 0);
    repeat (2) @(negedge sys_clk);
    chk("t1_word_cnt_held", ia.word_cnt, 3);

    // Underrun at the second word boundary.
    pulse_start(0, 3);
    run_ticks(0, 1, 16, 4, 8, 24, 16, 1'b0);
    chk("t3_underrun_set", ia.underrun, 1);
    chk("t3_busy_mid", ia.busy, 1);
    run_ticks(0, 17, 24, 4, 8, 24, 16, 1'b0);
    chk("t3_underrun_held", ia.underrun, 1);
    chk("t3_busy_end", ia.busy, 0);

    // Zero-length frame clears underrun and pulses frame_done only.
    push(0, cyc + 1, 1'b0, 1'b1);
    pulse_start(0, 0);
    chk("t5_underrun_clr", ia.underrun, 0);
    chk("t5_busy_zero", ia.busy, 0);
    @(negedge sys_clk);
    chk("t5_busy_stays", ia.busy, 0);

    // Start during RUN is ignored: 1-word frame still ends after 8 ticks.
    pulse_start(0, 1);
    run_ticks(0, 1, 4, 4, 8, 8, 0, 1'b0);
    pulse_start(0, 5);
    chk("t5_busy_after_ignored_start", ia.busy, 1);
    run_ticks(0, 5, 8, 4, 8, 8, 0, 1'b0);
    chk("t5_word_cnt", ia.word_cnt, 1);
    chk("t5_busy_end", ia.busy, 0);

    // Abort together with tick 13 of a 4-word frame.
    pulse_start(0, 4);
    run_ticks(0, 1, 12, 4, 8, 32, 0, 1'b0);
    chk("t4_bit_idx_pre", ia.bit_idx, 4);
    set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    @(negedge sys_clk);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_abort_busy", ia.busy, 0);
    chk("t4_abort_bit_idx", ia.bit_idx, 0);
    chk("t4_abort_word_cnt", ia.word_cnt, 0);
    repeat (4) @(negedge sys_clk);
    // Start together with abort in IDLE is dropped.
    set_in(0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    @(negedge sys_clk);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_abort_start_idle_busy", ia.busy, 0);
    pulse_start(0, 1);
    run_ticks(0, 1, 8, 4, 8, 8, 0, 1'b0);
    chk("t4_restart_word_cnt", ia.word_cnt, 1);

    // Prefetch: strobe with busy rising, then after the first boundary only.
    push(1, cyc + 1, 1'b1, 1'b0);
    pulse_start(1, 2);
    chk("t2_busy_rise", ib.busy, 1);
    run_ticks(1, 1, 16, 4, 8, 16, 0, 1'b1);
    chk("t2_word_cnt", ib.word_cnt, 2);
    chk("t2_busy_low", ib.busy, 0);

    // 12-bit words, 15-word frame on a 4-bit counter, back-to-back ticks.
    pulse_start(2, 15);
    run_ticks(2, 1, 180, 1, 12, 180, 0, 1'b0);
    chk("t6_word_cnt", ic.word_cnt, 15);
    chk("t6_busy_low", ic.busy, 0);

    // Reset mid-frame discards the frame.
    pulse_start(2, 15);
    run_ticks(2, 1, 30, 1, 12, 999, 0, 1'b0);
    chk("t6_busy_mid", ic.busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("t6_rst_busy", ic.busy, 0);
    chk("t6_rst_bit_idx", ic.bit_idx, 0);
    chk("t6_rst_word_cnt", ic.word_cnt, 0);
    chk("t6_rst_rd_en", ic.rd_en, 0);
    chk("t6_rst_frame_done", ic.frame_done, 0);
    chk("t6_rst_underrun", ic.underrun, 0);
    repeat (4) @(negedge sys_clk);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
